// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and elaboration helpers for the pipelined conditional-sum adder
package csa_pkg;

    typedef struct packed {
        logic sum0;
        logic sum1;
    } csa_pair_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int num_stages(input int width, input int pipe_every);
        int levels;
        levels = clog2(width);
        return (levels + pipe_every - 1) / pipe_every + 1;
    endfunction

    // Bits per dual-rail group at a merge level: 2^level sum bits plus the group carry.
    function automatic int group_width(input int level);
        return (1 << level) + 1;
    endfunction

endpackage

// File: rtl/csa_merge_level.sv
// rtl/csa_merge_level.sv - combinational merge of dual-rail 2^k-bit groups into 2^(k+1)-bit groups
module csa_merge_level
    import csa_pkg::*;
#(
    parameter int HW = 1,
    parameter int NG = 1
) (
    input  csa_pair_t [2*NG-1:0][HW:0]   halves,
    output csa_pair_t [NG-1:0][2*HW:0]   merged
);

    always_comb begin
        merged = '0;
        for (int g = 0; g < NG; g++) begin
            for (int i = 0; i < HW; i++) begin
                merged[g][i] = halves[2*g][i];
            end
            // The lower half's carry on each rail picks which upper-half rail follows it.
            for (int i = 0; i <= HW; i++) begin
                merged[g][HW+i].sum0 = halves[2*g][HW].sum0 ? halves[2*g+1][i].sum1
                                                            : halves[2*g+1][i].sum0;
                merged[g][HW+i].sum1 = halves[2*g][HW].sum1 ? halves[2*g+1][i].sum1
                                                            : halves[2*g+1][i].sum0;
            end
        end
    end

endmodule

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined conditional-sum adder with valid/ready and tag sideband
// Optional subtract mode (extra sub port) enabled by defining CSA_PIPE_SUB_EN.
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSA_PIPE_SUB_EN
    input  logic             sub,
`endif
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = clog2(WIDTH);
    localparam int NSTG   = num_stages(WIDTH, PIPE_EVERY);
    localparam int NMID   = NSTG - 1;

    logic adv;
    logic out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic cout_q, cout_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    assign adv       = !(out_valid_q && !out_ready);
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_tag   = out_tag_q;

    // Sideband pipe for stages 0..NSTG-2; the output stage holds its own copies.
    logic [NMID-1:0] vld_q, vld_d, cin_q, cin_d;
    logic [NMID-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] b_eff;
    logic carry_sel;
`ifdef CSA_PIPE_SUB_EN
    logic [NMID-1:0] sub_q, sub_d;
    assign b_eff     = sub ? ~b : b;
    assign carry_sel = cin_q[NMID-1] ^ sub_q[NMID-1];
`else
    assign b_eff     = b;
    assign carry_sel = cin_q[NMID-1];
`endif

    always_comb begin
        vld_d = vld_q;
        cin_d = cin_q;
        tag_d = tag_q;
`ifdef CSA_PIPE_SUB_EN
        sub_d = sub_q;
`endif
        if (adv) begin
            for (int s = NMID - 1; s > 0; s--) begin
                vld_d[s] = vld_q[s-1];
                cin_d[s] = cin_q[s-1];
                tag_d[s] = tag_q[s-1];
`ifdef CSA_PIPE_SUB_EN
                sub_d[s] = sub_q[s-1];
`endif
            end
            vld_d[0] = in_valid;
            cin_d[0] = cin;
            tag_d[0] = in_tag;
`ifdef CSA_PIPE_SUB_EN
            sub_d[0] = sub;
`endif
        end
    end

    csa_pair_t [WIDTH-1:0][1:0] leaf_q, leaf_d;

    always_comb begin
        leaf_d = leaf_q;
        if (adv) begin
            for (int i = 0; i < WIDTH; i++) begin
                leaf_d[i][0].sum0 = a[i] ^ b_eff[i];
                leaf_d[i][0].sum1 = ~(a[i] ^ b_eff[i]);
                leaf_d[i][1].sum0 = a[i] & b_eff[i];
                leaf_d[i][1].sum1 = a[i] | b_eff[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            cin_q  <= '0;
            tag_q  <= '0;
            leaf_q <= '0;
`ifdef CSA_PIPE_SUB_EN
            sub_q  <= '0;
`endif
        end else begin
            vld_q  <= vld_d;
            cin_q  <= cin_d;
            tag_q  <= tag_d;
            leaf_q <= leaf_d;
`ifdef CSA_PIPE_SUB_EN
            sub_q  <= sub_d;
`endif
        end
    end

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
        localparam int HW = 1 << (lv - 1);
        localparam int NG = WIDTH >> lv;

        csa_pair_t [2*NG-1:0][HW:0] src;
        csa_pair_t [NG-1:0][2*HW:0] mrg;
        csa_pair_t [NG-1:0][2*HW:0] q;

        if (lv == 1) begin : g_src
            assign src = leaf_q;
        end else begin : g_src
            assign src = g_lvl[lv-1].q;
        end

        csa_merge_level #(
            .HW (HW),
            .NG (NG)
        ) u_merge (
            .halves (src),
            .merged (mrg)
        );

        // The last level is left combinational; it feeds the carry-in select of the output stage.
        if ((lv % PIPE_EVERY) == 0 && lv < LEVELS) begin : g_reg
            csa_pair_t [NG-1:0][2*HW:0] lvl_q, lvl_d;

            always_comb begin
                lvl_d = adv ? mrg : lvl_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lvl_q <= '0;
                end else begin
                    lvl_q <= lvl_d;
                end
            end

            assign q = lvl_q;
        end else begin : g_comb
            assign q = mrg;
        end
    end

    csa_pair_t [WIDTH:0] top_rail;
    logic [WIDTH:0] result;

    assign top_rail = g_lvl[LEVELS].q[0];

    always_comb begin
        result = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            result[i] = carry_sel ? top_rail[i].sum1 : top_rail[i].sum0;
        end
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_tag_d   = out_tag_q;
        if (adv) begin
            out_valid_d = vld_q[NMID-1];
            sum_d       = result[WIDTH-1:0];
            cout_d      = result[WIDTH];
            out_tag_d   = tag_q[NMID-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_tag_q   <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - self-checking bench for csa_pipe_adder (default parameters)
module tb_csa_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub_in;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic [3:0]  out_tag;

    int n_checks;
    int n_fail;
    logic [36:0] sb[$];
    logic        hold_prev;
    logic [37:0] prev_out;
    logic        rand_done;

    csa_pipe_adder u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CSA_PIPE_SUB_EN
        .sub       (sub_in),
`endif
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the full-width arithmetic result, tag in the top bits.
    function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s, input logic [3:0] t);
        logic [32:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + {32'd0, !c};
        else   r = {1'b0, x} + {1'b0, y} + {32'd0, c};
        return {t, r};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                check_eq("stall_hold", {26'd0, out_valid, out_tag, cout, sum}, {26'd0, prev_out});
            hold_prev = out_valid && !out_ready;
            prev_out  = {out_valid, out_tag, cout, sum};
            if (in_valid && in_ready)
                sb.push_back(model(a, b, cin, sub_in, in_tag));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_beat", {27'd0, out_tag, cout, sum}, 64'hdead);
                end else begin
                    check_eq("sb_result", {27'd0, out_tag, cout, sum}, {27'd0, sb.pop_front()});
                end
            end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] ta, input logic [31:0] tb_v,
                              input logic tc, input logic [3:0] tt);
        bit ok;
        a = ta; b = tb_v; cin = tc; in_tag = tt; in_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output logic [31:0] s, output logic c, output logic [3:0] t);
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        s = sum; c = cout; t = out_tag;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check_eq("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int stale;
        logic [31:0] rs;
        logic rc;
        logic [3:0] rt;

        n_checks = 0; n_fail = 0; hold_prev = 0; prev_out = '0; rand_done = 0;
        rst_n = 1'b0; in_valid = 0; a = 0; b = 0; cin = 0; sub_in = 0; in_tag = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_sum", {out_tag, cout, sum}, 0);
        rst_n = 1'b1;

        // Carry ripples across the whole word.
        to_drive();
        drive_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd3);
        wait_out(lat, rs, rc, rt);
        check_eq("t1_latency", lat, 4);
        check_eq("t1_sum", rs, 32'h0);
        check_eq("t1_cout", rc, 1);
        check_eq("t1_tag", rt, 3);
        @(negedge clk);
        check_eq("t1_one_cycle", out_valid, 0);

        // Back-to-back beats come out on consecutive cycles.
        to_drive();
        drive_beat(32'hCD, 32'hFC, 1'b1, 4'd5);
        drive_beat(32'h33, 32'h77, 1'b0, 4'd6);
        wait_out(lat, rs, rc, rt);
        check_eq("b2b_latency", lat, 3);
        check_eq("b2b_first", {rt, rc, rs}, {4'd5, 1'b0, 32'h1CA});
        @(negedge clk);
        check_eq("b2b_second_valid", out_valid, 1);
        check_eq("b2b_second", {out_tag, cout, sum}, {4'd6, 1'b0, 32'hAA});

        // Wrap without saturation.
        to_drive();
        drive_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd9);
        wait_out(lat, rs, rc, rt);
        check_eq("wrap_latency", lat, 4);
        check_eq("wrap_result", {rt, rc, rs}, {4'd9, 1'b1, 32'hFFFF_FFFF});

        // Six-beat stream with a three-cycle downstream stall.
        to_drive();
        fork
            begin
                for (int i = 0; i < 6; i++)
                    drive_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i + 1));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", in_ready, 0);
                    check_eq("stall_out_valid", out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with beats in flight.
        to_drive();
        drive_beat(32'h1111, 32'h2222, 1'b0, 4'd1);
        drive_beat(32'h3333, 32'h4444, 1'b1, 4'd2);
        drive_beat(32'h5555, 32'h6666, 1'b0, 4'd4);
        wait_out(lat, rs, rc, rt);
        check_eq("rst_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_valid", out_valid, 0);
        check_eq("rst_async_sum", {out_tag, cout, sum}, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_eq("rst_no_stale", stale, 0);
        to_drive();
        drive_beat(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd7);
        wait_out(lat, rs, rc, rt);
        check_eq("rst_fresh_latency", lat, 4);
        check_eq("rst_fresh_result", {rt, rc, rs}, {4'd7, 1'b1, 32'h1});

`ifdef CSA_PIPE_SUB_EN
        to_drive();
        sub_in = 1'b1;
        drive_beat(32'd5, 32'd7, 1'b0, 4'd2);
        wait_out(lat, rs, rc, rt);
        check_eq("sub_neg", {rc, rs}, {1'b0, 32'hFFFF_FFFE});
        to_drive();
        drive_beat(32'd7, 32'd5, 1'b0, 4'd3);
        wait_out(lat, rs, rc, rt);
        check_eq("sub_pos", {rc, rs}, {1'b1, 32'd2});
        sub_in = 1'b0;
`endif

        // Random beats with random backpressure against the scoreboard.
        to_drive();
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    if (!rand_done) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 2000; i++) begin
                    logic [31:0] ra;
                    logic [31:0] rb;
                    if ($urandom_range(0, 3) == 0) to_drive();
                    ra = $urandom;
                    rb = $urandom;
                    if ($urandom_range(0, 15) == 0) ra = 32'hFFFF_FFFF;
                    if ($urandom_range(0, 15) == 0) rb = 32'hFFFF_FFFF;
`ifdef CSA_PIPE_SUB_EN
                    sub_in = 1'($urandom_range(0, 1));
`endif
                    drive_beat(ra, rb, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                end
                rand_done = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
- Parametrised, pipelined conditional-sum adder. Successor to the fixed 16-bit combinational conditional-sum adder.
- Builds the same dual-rail (carry-in 0 / carry-in 1) sum tree for any power-of-two width.
- Registers the tree every PIPE_EVERY merge levels and resolves the real carry-in at the last stage.
- Uses valid/ready handshakes on both sides and carries a tag sideband, so it can sit between streaming datapath stages.

Parameters:
- WIDTH, 32: operand width. Power of two, 2..64.
- PIPE_EVERY, 2: merge levels between pipeline registers. 1..log2(WIDTH).
- TAG_W, 4: sideband tag width, passed through unchanged. Must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  a+b+cin, low WIDTH bits.
- cout  out  1  carry-out (bit WIDTH of the full result).
- out_tag  out  TAG_W  tag of the beat shown on sum.

Behaviour:
- Constants:
  - LEVELS = log2(WIDTH).
  - NSTG = ceil(LEVELS/PIPE_EVERY) + 1 register stages.
  - Stage 0 is the input register (leaf 1-bit dual sums).
  - The last stage applies the cin select.
- Latency: exactly NSTG cycles from an accepted beat (in_valid && in_ready) to out_valid for that beat, when out_ready is held high. Default config is 4 cycles.
- Throughput: one beat per cycle while out_ready=1.
- Arithmetic:
  - Each merge level takes the upper half of the carry-in-0 result when the lower half's carry-in-0 carry is 0; otherwise it takes the upper half of the carry-in-1 result.
  - The carry-in-1 result uses the lower carry-in-1 carry for the same choice.
  - {cout,sum} must equal a+b+cin as an unsigned WIDTH+1-bit value for all inputs.
- cin and tag travel in registers alongside the dual-rail data and are consumed only at the final select.
- Stall: stall = out_valid && !out_ready.
  - The whole pipeline holds, with no bubble collapse.
  - in_ready = !stall, purely combinational.
  - While stalled, sum, cout, out_tag and out_valid are held stable.
- Each stage has its own valid bit. Bubbles propagate as invalid stages; data in invalid stages is don't-care.
- in_valid with in_ready=0: the beat is not accepted. The source must hold it.
- out_valid must not depend combinationally on out_ready.
- Reset (async assert, synchronous release):
  - All stage valid bits clear, so out_valid=0.
  - in_ready=1 after reset because out_valid=0.
  - sum, cout and out_tag reset to 0.
  - In-flight beats are discarded with no partial output.
- Wrap: all-ones + all-ones + 1 gives sum=all-ones, cout=1. No saturation.

Optional Feature:
- Macro: CSA_PIPE_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the beat.
  - When sub=1, the block computes a − b − cin, implemented as a + ~b + !cin.
  - cout=1 means no borrow.
  - sub is pipelined with the beat; latency is unchanged.
- Undefined: no sub port; addition only.

Decomposition:
- Package csa_pkg holds:
  - function clog2.
  - function num_stages(width, pipe_every).
  - typedef of the dual-rail pair struct {sum0, sum1} sized per level, generated by the width function.
- One sub-module, csa_merge_level, is natural. It is a combinational merge of 2^k-bit dual-rail halves into 2^(k+1) bits.
- csa_pipe_adder generates LEVELS merge levels, the stage registers, valid/tag pipes and the final cin select.

Test Plan:
- Default config, out_ready=1, beat a=0xFFFFFFFF, b=0x00000001, cin=0, tag=3 → 4 cycles later sum=0x00000000, cout=1, out_tag=3, out_valid for 1 cycle.
- Back-to-back beats (0xCD+0xFC, cin=1) then (0x33+0x77, cin=0) on consecutive cycles → results 0x1CA then 0xAA on consecutive cycles, tags in order.
- Stream 6 beats, drop out_ready for 3 cycles mid-stream → in_ready=0 during the stall, output held stable, no beat lost or duplicated, order kept.
- Assert rst_n low with 3 beats in flight → out_valid=0 immediately (async), no stale result appears after release, a fresh beat completes with normal latency.
- WIDTH=16, PIPE_EVERY=1 → latency 5. 10k random beats with random out_ready match a reference model of {cout,sum}.
- With CSA_PIPE_SUB_EN: a=5, b=7, cin=0, sub=1 → sum=0xFFFFFFFE, cout=0. a=7, b=5, sub=1 → sum=2, cout=1.
